// File: rtl/reg_scoreboard.sv
// reg_scoreboard: producer-side hazard tracker for a 5-stage RISC-V pipeline.
// Shadows the in-flight register writers in E, M and W. Stalls a consumer in D
// that the bypass network cannot serve, issues the branch flushes, and counts
// stall cycles with a counter that saturates instead of wrapping.
//
// Build option: define SCB_FORWARD_EN when the core has EX forwarding. Only a
// load sitting in E then stalls its consumer (load-use). Without the macro the
// block is a full interlock: any writer in E or M stalls a reader of its rd.
module reg_scoreboard #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             useRs1D,
  input  logic             useRs2D,
  input  logic [4:0]       rdD,
  input  logic             RegWriteD,
  input  logic             MemReadD,
  input  logic             branchTakenE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int NSLOT = 3;
  localparam int S_E   = 0;
  localparam int S_M   = 1;
  localparam int S_W   = 2;

  logic             slot_v_q  [NSLOT];
  logic             slot_v_d  [NSLOT];
  logic [4:0]       slot_rd_q [NSLOT];
  logic [4:0]       slot_rd_d [NSLOT];
  logic             slot_ld_q [NSLOT];
  logic             slot_ld_d [NSLOT];
  logic             hit1      [NSLOT];
  logic             hit2      [NSLOT];
  logic             hazard;
  logic             issue;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Per-slot match of each D source against the recorded writer. x0 and
  // sources the instruction does not read can never match.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      hit1[s] = useRs1D && (rs1D != 5'd0) && slot_v_q[s] && (slot_rd_q[s] == rs1D);
      hit2[s] = useRs2D && (rs2D != 5'd0) && slot_v_q[s] && (slot_rd_q[s] == rs2D);
    end
  end

  // Hazard decision. W never stalls: the register file writes before it reads.
  always_comb begin
`ifdef SCB_FORWARD_EN
    hazard = (hit1[S_E] || hit2[S_E]) && slot_ld_q[S_E];
`else
    hazard = hit1[S_E] || hit1[S_M] || hit2[S_E] || hit2[S_M];
`endif
  end

  // Pipeline control. A taken branch wins: the D instruction is wrong-path,
  // so it is flushed rather than stalled.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (branchTakenE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (hazard) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign issue     = RegWriteD && (rdD != 5'd0) && !stallD && !flushE;
  assign stall_cnt = stall_cnt_q;

  // Next state: shift writers down the pipe every cycle. A bubble enters E
  // fully cleared so stale rd/ld bits never linger. Counter saturates.
  always_comb begin
    slot_v_d[S_W]  = slot_v_q[S_M];
    slot_rd_d[S_W] = slot_rd_q[S_M];
    slot_ld_d[S_W] = slot_ld_q[S_M];
    slot_v_d[S_M]  = slot_v_q[S_E];
    slot_rd_d[S_M] = slot_rd_q[S_E];
    slot_ld_d[S_M] = slot_ld_q[S_E];
    slot_v_d[S_E]  = 1'b0;
    slot_rd_d[S_E] = 5'd0;
    slot_ld_d[S_E] = 1'b0;
    if (issue) begin
      slot_v_d[S_E]  = 1'b1;
      slot_rd_d[S_E] = rdD;
      slot_ld_d[S_E] = MemReadD;
    end
    stall_cnt_d = stall_cnt_q;
    if (stallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSLOT; s++) begin
        slot_v_q[s]  <= 1'b0;
        slot_rd_q[s] <= 5'd0;
        slot_ld_q[s] <= 1'b0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int s = 0; s < NSLOT; s++) begin
        slot_v_q[s]  <= slot_v_d[s];
        slot_rd_q[s] <= slot_rd_d[s];
        slot_ld_q[s] <= slot_ld_d[s];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard. A driver applies one D-stage
// instruction per cycle, predicts the control outputs from a list of issued
// writers tagged with their age in cycles, and queues the prediction. A
// monitor on the falling edge pops and compares. Uses a 4-bit stall counter
// so saturation is reachable.
module tb_reg_scoreboard;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic [4:0]       rs1D, rs2D, rdD;
  logic             useRs1D, useRs2D, RegWriteD, MemReadD, branchTakenE;
  logic             stallF, stallD, flushD, flushE;
  logic [CNT_W-1:0] stall_cnt;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
    .rdD(rdD), .RegWriteD(RegWriteD), .MemReadD(MemReadD),
    .branchTakenE(branchTakenE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int rd;
    bit ld;
    int age;   // cycles since the writer left D
  } writer_t;

  typedef struct {
    int cyc;
    bit sF, sD, fD, fE;
    int cnt;
  } exp_t;

  writer_t inflight[$];
  exp_t    expq[$];
  int      m_cnt   = 0;
  int      cyc     = 0;
  int      n_chk   = 0;
  int      n_fail  = 0;
  bit      running = 1'b0;

  // A source is blocked if some writer of that register is still too young
  // for the result to be reachable.
  function automatic bit src_blocked(input int rs, input bit use_rs);
    if (!use_rs || rs == 0) return 1'b0;
    foreach (inflight[i]) begin
      if (inflight[i].rd == rs) begin
`ifdef SCB_FORWARD_EN
        if (inflight[i].age == 1 && inflight[i].ld) return 1'b1;
`else
        if (inflight[i].age <= 2) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  task automatic step(input bit rstn, input int r1, input int r2, input bit u1, input bit u2,
                      input int rd, input bit rw, input bit mr, input bit br);
    exp_t    e;
    writer_t w;
    bit      haz, iss;
    reset_n      = rstn;
    rs1D         = 5'(r1);
    rs2D         = 5'(r2);
    useRs1D      = u1;
    useRs2D      = u2;
    rdD          = 5'(rd);
    RegWriteD    = rw;
    MemReadD     = mr;
    branchTakenE = br;
    if (!rstn) begin
      inflight.delete();
      m_cnt = 0;
    end
    haz   = src_blocked(r1, u1) || src_blocked(r2, u2);
    e.cyc = cyc;
    e.fD  = br;
    e.fE  = br || haz;
    e.sD  = !br && haz;
    e.sF  = e.sD;
    e.cnt = m_cnt;
    expq.push_back(e);
    iss = rstn && rw && (rd != 0) && !br && !haz;
    @(posedge clk);
    if (rstn) begin
      if (e.sD && m_cnt < CNT_MAX) m_cnt++;
      foreach (inflight[i]) inflight[i].age++;
      while (inflight.size() > 0 && inflight[0].age > 2) void'(inflight.pop_front());
      if (iss) begin
        w.rd  = rd;
        w.ld  = mr;
        w.age = 1;
        inflight.push_back(w);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input int cy, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cy, got, want);
    end
  endtask

  // Monitor: one prediction per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL no_prediction cyc=%0d got=0 exp=1", cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("stallF",    e.cyc, int'(stallF),    int'(e.sF));
        chk("stallD",    e.cyc, int'(stallD),    int'(e.sD));
        chk("flushD",    e.cyc, int'(flushD),    int'(e.fD));
        chk("flushE",    e.cyc, int'(flushE),    int'(e.fE));
        chk("stall_cnt", e.cyc, int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    reset_n = 1'b0; rs1D = '0; rs2D = '0; rdD = '0;
    useRs1D = 1'b0; useRs2D = 1'b0; RegWriteD = 1'b0; MemReadD = 1'b0; branchTakenE = 1'b0;
    @(posedge clk);
    #1;
    running = 1'b1;
    // reset state, including flushE following the branch input during reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5, 5, 1, 1, 5, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ALU dependence on x5
    step(1, 0, 0, 0, 0, 5, 1, 0, 0);
    repeat (3) step(1, 5, 0, 1, 0, 6, 1, 0, 0);
    // load-use on x7 via rs2
    step(1, 0, 0, 0, 0, 7, 1, 1, 0);
    repeat (3) step(1, 0, 7, 0, 1, 8, 1, 0, 0);
    // x0 writer and x0 reader; unused matching rs2
    step(1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 9, 1, 0, 0);
    step(1, 1, 9, 1, 0, 0, 0, 0, 0);
    // branch overrides a hazard on x3, then bubble
    step(1, 0, 0, 0, 0, 3, 1, 1, 0);
    step(1, 3, 3, 1, 1, 4, 1, 0, 1);
    step(1, 3, 0, 1, 0, 4, 1, 0, 0);
    step(1, 3, 0, 1, 0, 4, 1, 0, 0);
    // reset mid-stall with x5 writers in E and M
    step(1, 0, 0, 0, 0, 5, 1, 1, 0);
    step(1, 0, 0, 0, 0, 6, 1, 0, 0);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0);
    step(0, 5, 0, 1, 0, 0, 0, 0, 0);
    step(1, 5, 0, 1, 0, 0, 0, 0, 0);
    // saturation: self-dependent loads on x5 keep the counter climbing
    repeat (45) step(1, 5, 5, 1, 1, 5, 1, 1, 0);
    // randomized traffic over a small register set so hazards are frequent
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 39) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    running = 1'b0;
    if (expq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL leftover_predictions got=%0d exp=0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
